// File: rtl/pixel_pattern_pkg.sv
// pixel_pattern_pkg: shared state type, widths and ramp-pattern helpers for the pixel pattern checker
package pixel_pattern_pkg;
  localparam int IDX_W = 4;
  localparam int PIX_W = 8;
  typedef enum logic [1:0] {HUNT, ACQ, LOCKED} check_state_t;
  function automatic logic [PIX_W-1:0] pattern_pixel(input logic [IDX_W-1:0] idx);
    return {idx, idx};
  endfunction
  function automatic logic is_seed(input logic [PIX_W-1:0] pixel);
    return pixel[PIX_W-1:IDX_W] == pixel[IDX_W-1:0];
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter; ports clk, reset_n (async low), inc, clr (priority over inc), count
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) count <= '0;
    else if (clr) count <= '0;
    else if (inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/pixel_pattern_checker.sv
// pixel_pattern_checker: locks onto the idx*0x11 ramp and checks each beat; ports clk, reset_n (async low), pixel_valid, pixel, clear -> locked, error, err_count, beat_count
module pixel_pattern_checker
  import pixel_pattern_pkg::*;
#(
  parameter int STRIDE     = 2,
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pixel_valid,
  input  logic [PIX_W-1:0] pixel,
  input  logic             clear,
  output logic             locked,
  output logic             error,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] beat_count
);
  // truncation to the idx width gives the mod-16 stride
  localparam logic [IDX_W-1:0] STEP   = IDX_W'(STRIDE);
  localparam logic [IDX_W-1:0] LOCK_N = IDX_W'(LOCK_COUNT);
  localparam logic [IDX_W-1:0] LOSS_N = IDX_W'(LOSS_COUNT);
  check_state_t state, state_n;
  logic [IDX_W-1:0] exp_idx, exp_n, run, run_n, miss, miss_n;
  logic match, seed, err_n, beat_n;
  always_comb begin
    match   = pixel == pattern_pixel(exp_idx);
    seed    = is_seed(pixel);
    state_n = state;
    exp_n   = exp_idx;
    run_n   = run;
    miss_n  = miss;
    err_n   = 1'b0;
    beat_n  = 1'b0;
    if (pixel_valid)
      case (state)
        HUNT: if (seed) begin
          exp_n   = pixel[IDX_W-1:0] + STEP;
          run_n   = IDX_W'(1);
          state_n = ACQ;
        end
        ACQ: if (match) begin
          run_n   = run + 1'b1;
          exp_n   = exp_idx + STEP;
          state_n = run_n == LOCK_N ? LOCKED : ACQ;
        end else if (seed) begin
          exp_n = pixel[IDX_W-1:0] + STEP;
          run_n = IDX_W'(1);
        end else state_n = HUNT;
        // no reseed while locked so a corrupted beat cannot shift alignment
        LOCKED: begin
          beat_n = 1'b1;
          exp_n  = exp_idx + STEP;
          err_n  = !match;
          miss_n = match ? '0 : miss + 1'b1;
          if (miss_n == LOSS_N) begin
            state_n = HUNT;
            miss_n  = '0;
          end
        end
        default: state_n = HUNT;
      endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state   <= HUNT;
      exp_idx <= '0;
      run     <= '0;
      miss    <= '0;
      locked  <= 1'b0;
      error   <= 1'b0;
    end else begin
      state   <= state_n;
      exp_idx <= exp_n;
      run     <= run_n;
      miss    <= miss_n;
      locked  <= state_n == LOCKED;
      error   <= err_n;
    end
  sat_counter #(.W(CNT_W)) u_err (
    .clk(clk), .reset_n(reset_n), .inc(err_n), .clr(clear), .count(err_count)
  );
  sat_counter #(.W(CNT_W)) u_beat (
    .clk(clk), .reset_n(reset_n), .inc(beat_n), .clr(clear), .count(beat_count)
  );
endmodule

// File: tb/tb_pixel_pattern_checker.sv
// tb_pixel_pattern_checker: directed scoreboard bench for pixel_pattern_checker (16-bit and 2-bit counter instances)
module tb_pixel_pattern_checker;
  logic clk = 1'b0, reset_n = 1'b0, pixel_valid = 1'b0, clear = 1'b0;
  logic [7:0] pixel = 8'h5A;
  logic locked, error, locked2, error2;
  logic [15:0] err_count, beat_count;
  logic [1:0] err_count2, beat_count2;
  typedef struct {
    logic        l;
    logic        e;
    logic [15:0] ec;
    logic [15:0] bc;
  } exp_t;
  exp_t sb[$];
  int n_cmp = 0, n_bad = 0;
  logic xl = 1'b0;
  logic [15:0] xec = '0, xbc = '0;
  bit gap = 1'b1;
  always #5 clk = ~clk;
  pixel_pattern_checker dut (
    .clk(clk), .reset_n(reset_n), .pixel_valid(pixel_valid), .pixel(pixel), .clear(clear),
    .locked(locked), .error(error), .err_count(err_count), .beat_count(beat_count)
  );
  pixel_pattern_checker #(.CNT_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .pixel_valid(pixel_valid), .pixel(pixel), .clear(clear),
    .locked(locked2), .error(error2), .err_count(err_count2), .beat_count(beat_count2)
  );
  function automatic logic [15:0] sat2(input logic [15:0] v);
    return v > 16'd3 ? 16'd3 : v;
  endfunction
  task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic check();
    exp_t x;
    x = sb.pop_front();
    cmp("locked", 16'(locked), 16'(x.l));
    cmp("error", 16'(error), 16'(x.e));
    cmp("err_count", err_count, x.ec);
    cmp("beat_count", beat_count, x.bc);
    cmp("locked_w2", 16'(locked2), 16'(x.l));
    cmp("error_w2", 16'(error2), 16'(x.e));
    cmp("err_count_w2", 16'(err_count2), sat2(x.ec));
    cmp("beat_count_w2", 16'(beat_count2), sat2(x.bc));
  endtask
  task automatic idle();
    @(negedge clk);
    pixel_valid = 1'b0;
    pixel = 8'h5A;
    clear = 1'b0;
    sb.push_back('{xl, 1'b0, xec, xbc});
    @(posedge clk);
    #1 check();
  endtask
  task automatic send(input logic [7:0] p, input logic l, input logic e, input logic c = 1'b0);
    @(negedge clk);
    pixel_valid = 1'b1;
    pixel = p;
    clear = c;
    if (xl) xbc++;
    if (e) xec++;
    if (c) begin
      xec = '0;
      xbc = '0;
    end
    xl = l;
    sb.push_back('{xl, e, xec, xbc});
    @(posedge clk);
    #1 check();
    if (gap) idle();
  endtask
  initial begin
    @(posedge clk);
    #1 sb.push_back('{1'b0, 1'b0, 16'd0, 16'd0});
    check();
    @(negedge clk) reset_n = 1'b1;
    // clean stream from reset
    send(8'h00, 0, 0); send(8'h22, 0, 0); send(8'h44, 0, 0); send(8'h66, 1, 0);
    send(8'h88, 1, 0); send(8'hAA, 1, 0); send(8'hCC, 1, 0); send(8'hEE, 1, 0);
    send(8'h00, 1, 0); send(8'h22, 1, 0); send(8'h44, 1, 0); send(8'h66, 1, 0);
    // single corrupted beat keeps alignment
    send(8'h89, 1, 1); send(8'hAA, 1, 0);
    // three misses lose lock, then relock after four clean beats
    send(8'h13, 1, 1); send(8'h13, 1, 1); send(8'h13, 0, 1);
    send(8'h22, 0, 0); send(8'h44, 0, 0); send(8'h66, 0, 0); send(8'h88, 1, 0);
    // clear coincident with an error
    send(8'hAB, 1, 1, 1'b1); send(8'hCC, 1, 0);
    // five separated errors saturate the 2-bit counter
    send(8'hEF, 1, 1); send(8'h00, 1, 0); send(8'h23, 1, 1); send(8'h44, 1, 0);
    send(8'h67, 1, 1); send(8'h88, 1, 0); send(8'hAB, 1, 1); send(8'hCC, 1, 0);
    send(8'hEF, 1, 1);
    // asynchronous reset between edges while locked
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 sb.push_back('{1'b0, 1'b0, 16'd0, 16'd0});
    check();
    xl = 1'b0;
    xec = '0;
    xbc = '0;
    @(negedge clk) reset_n = 1'b1;
    // non-seed miss in ACQ returns to HUNT, seed miss reseeds, wrap EE->00
    send(8'h00, 0, 0); send(8'h22, 0, 0); send(8'h45, 0, 0); send(8'h12, 0, 0);
    send(8'h33, 0, 0); send(8'h55, 0, 0); send(8'h77, 0, 0); send(8'hAA, 0, 0);
    send(8'hCC, 0, 0); send(8'hEE, 0, 0); send(8'h00, 1, 0);
    // back-to-back beats
    gap = 1'b0;
    send(8'h22, 1, 0); send(8'h44, 1, 0); send(8'h67, 1, 1); send(8'h88, 1, 0);
    gap = 1'b1;
    idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
